// File: rtl/capture_pkg.sv
// capture_pkg: register offsets, register/status layouts and address decode for capture_timer
package capture_pkg;
  localparam logic [11:0] CAPTURE_CR_OFFSET   = 12'h000;
  localparam logic [11:0] CAPTURE_SR_OFFSET   = 12'h004;
  localparam logic [11:0] CAPTURE_CNTR_OFFSET = 12'h008;
  localparam logic [11:0] CAPTURE_CAPR_OFFSET = 12'h00C;
  typedef enum logic [2:0] {CR, SR, CNTR, CAPR, NONE} capture_reg_t;
  typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH} capture_edge_t;
  typedef struct packed {
    logic          clr;
    logic          ie;
    capture_edge_t edge_sel;
    logic          en;
  } capture_cr_t;
  typedef struct packed {
    logic wrap;
    logic ovr;
    logic cap;
  } capture_sr_t;
  function automatic capture_reg_t reg_decode(input logic [11:0] addr);
    return addr == CAPTURE_CR_OFFSET   ? CR   :
           addr == CAPTURE_SR_OFFSET   ? SR   :
           addr == CAPTURE_CNTR_OFFSET ? CNTR :
           addr == CAPTURE_CAPR_OFFSET ? CAPR : NONE;
  endfunction
endpackage

// File: rtl/capture_edge_detect.sv
// capture_edge_detect: cap_in synchronizer, optional stability filter (CAPTURE_TIMER_FILTER_EN), rise/fall pulses
module capture_edge_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cap_in,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic level;
  logic prev;
  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
    $error("capture_edge_detect: SYNC_STAGES >= 2 and FILTER_LEN >= 1 required");
  end
  always_ff @(posedge clk) begin
    sync <= rst ? '0 : {sync[SYNC_STAGES-2:0], cap_in};
    prev <= rst ? 1'b0 : level;
  end
`ifdef CAPTURE_TIMER_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] cnt;
  // level follows the synced pin only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == level) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      cnt   <= '0;
      level <= sync[SYNC_STAGES-1];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign level = sync[SYNC_STAGES-1];
`endif
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/capture_timer.sv
// capture_timer: bus-mapped input capture; optional pin stability filter via CAPTURE_TIMER_FILTER_EN
module capture_timer
  import capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [11:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  input  logic        cap_in,
  output logic        irq
);
  capture_cr_t  cr;
  capture_sr_t  sr;
  capture_reg_t sel;
  logic [31:0]  cntr;
  logic [31:0]  capr;
  logic [31:0]  rdata_d;
  logic [2:0]   w1c;
  logic         rise, fall, evt, wr, rd, clr, cntr_wr, cap_rd, wrap_evt;
  capture_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_edge (
    .clk   (clk),
    .rst   (rst),
    .cap_in(cap_in),
    .rise  (rise),
    .fall  (fall)
  );
  always_comb begin
    sel      = reg_decode(bus_addr);
    wr       = bus_req & bus_we;
    rd       = bus_req & ~bus_we;
    clr      = wr && sel == CR && bus_wdata[4];
    cntr_wr  = wr && sel == CNTR;
    cap_rd   = rd && sel == CAPR;
    w1c      = (wr && sel == SR) ? bus_wdata[2:0] : 3'b0;
    evt      = cr.en && ((rise && cr.edge_sel[0]) || (fall && cr.edge_sel[1]));
    wrap_evt = cr.en && !clr && !cntr_wr && &cntr;
    rdata_d  = sel == CR   ? {27'b0, cr} :
               sel == SR   ? {29'b0, sr} :
               sel == CNTR ? cntr :
               sel == CAPR ? capr : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cr         <= '0;
      sr         <= '0;
      cntr       <= '0;
      capr       <= '0;
      irq        <= 1'b0;
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_req;
      bus_rdata  <= rd ? rdata_d : 32'b0;
      irq        <= cr.ie & (sr.cap | sr.ovr);
      if (wr && sel == CR) cr <= capture_cr_t'({1'b0, bus_wdata[3:0]});
      cntr <= clr ? 32'b0 : cntr_wr ? bus_wdata : cr.en ? cntr + 32'd1 : cntr;
      // the timestamp is the count of the detect cycle, before any write or increment lands
      if (evt) capr <= cntr;
      sr.cap  <= evt | (sr.cap & ~cap_rd & ~w1c[0]);
      sr.ovr  <= (evt & sr.cap) | (sr.ovr & ~w1c[1]);
      sr.wrap <= wrap_evt | (sr.wrap & ~w1c[2]);
    end
  end
endmodule

// File: tb/tb_capture_timer.sv
// tb_capture_timer: randomized scoreboard bench for capture_timer against a cycle-level reference model
module tb_capture_timer;
  localparam int S = 2;
  localparam int L = 4;
  localparam int N = 8192;
`ifdef CAPTURE_TIMER_FILTER_EN
  localparam int LAT = S + L;
`else
  localparam int LAT = S;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [11:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        cap_in = 1'b0;
  logic        irq;
  always #5 clk = ~clk;
  capture_timer #(.SYNC_STAGES(S), .FILTER_LEN(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_rvalid(bus_rvalid),
    .cap_in    (cap_in),
    .irq       (irq)
  );
  typedef struct {
    int          due;
    logic        rd;
    logic [31:0] data;
    logic [11:0] addr;
  } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic        pin[N];
  logic        lvl[N];
  logic [11:0] addrs[6] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'hFFC};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          run = 0;
  logic        cap_lvl = 1'b0;
  logic        m_en, m_ie, m_cap, m_ovr, m_wrap, m_irq;
  logic [1:0]  m_edge;
  logic [31:0] m_cnt, m_capr, v;

  // synced pin seen in cycle k is the pin driven S cycles earlier; zero before that
  function automatic logic synced(int k);
    return (k >= S) ? pin[k-S] : 1'b0;
  endfunction

  function automatic logic level_at(int k);
`ifdef CAPTURE_TIMER_FILTER_EN
    logic p;
    p = (k > 0) ? lvl[k-1] : 1'b0;
    for (int i = 1; i <= L; i++) if (synced(k - i) == p) return p;
    return !p;
`else
    return synced(k);
`endif
  endfunction

  task automatic model_reset();
    {m_en, m_ie, m_cap, m_ovr, m_wrap, m_irq, m_edge} = '0;
    m_cnt  = '0;
    m_capr = '0;
  endtask

  task automatic step(input logic req, input logic we, input logic [11:0] a, input logic [31:0] wd);
    logic        r, f, ev, clr, cw, crd;
    logic [2:0]  w1c;
    logic [31:0] rv;
    bus_req   = req;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = wd;
    cap_in    = cap_lvl;
    pin[cyc]  = cap_lvl;
    lvl[cyc]  = level_at(cyc);
    r  = lvl[cyc] && !(cyc > 0 && lvl[cyc-1]);
    f  = !lvl[cyc] && cyc > 0 && lvl[cyc-1];
    ev = m_en && ((r && m_edge[0]) || (f && m_edge[1]));
    rv = a == 12'h000 ? {28'b0, m_ie, m_edge, m_en} :
         a == 12'h004 ? {29'b0, m_wrap, m_ovr, m_cap} :
         a == 12'h008 ? m_cnt :
         a == 12'h00C ? m_capr : 32'b0;
    if (req) sb.push_back('{due: cyc, rd: !we, data: rv, addr: a});
    clr = req && we && a == 12'h000 && wd[4];
    cw  = req && we && a == 12'h008;
    crd = req && !we && a == 12'h00C;
    w1c = (req && we && a == 12'h004) ? wd[2:0] : 3'b0;
    m_irq  = m_ie && (m_cap || m_ovr);
    m_wrap = (m_en && !clr && !cw && m_cnt == 32'hFFFF_FFFF) || (m_wrap && !w1c[2]);
    m_ovr  = (ev && m_cap) || (m_ovr && !w1c[1]);
    m_cap  = ev || (m_cap && !crd && !w1c[0]);
    if (ev) m_capr = m_cnt;
    m_cnt = clr ? 32'b0 : cw ? wd : m_en ? m_cnt + 32'd1 : m_cnt;
    if (req && we && a == 12'h000) {m_ie, m_edge, m_en} = wd[3:0];
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 12'h000, 32'b0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b1, 1'b0, a, 32'b0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus_req = 1'b0;
    cap_in  = cap_lvl;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    sb.delete();
    model_reset();
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      checks++;
      if (irq !== m_irq) begin
        errors++;
        $display("FAIL irq cyc=%0d got %b expected %b", cyc, irq, m_irq);
      end
      if (bus_rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rvalid cyc=%0d got unexpected acknowledge", cyc);
        end else begin
          e = sb.pop_front();
          if (e.due != cyc) begin
            errors++;
            $display("FAIL ack_timing addr=%h got cyc %0d expected cyc %0d", e.addr, cyc, e.due);
          end else if (e.rd && bus_rdata !== e.data) begin
            errors++;
            $display("FAIL rdata addr=%h cyc=%0d got %h expected %h", e.addr, cyc, bus_rdata, e.data);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rvalid_missing addr=%h cyc=%0d got 0 expected 1", sb[0].addr, cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) rd(addrs[i]);
    wr(12'h008, 32'hFFFF_FFFE);
    wr(12'h000, 32'h1);
    idle(2);
    rd(12'h008);
    rd(12'h004);
    wr(12'h004, 32'h4);
    rd(12'h004);
    wr(12'h000, 32'h3);
    wr(12'h008, 32'd100);
    cap_lvl = 1'b1;
    idle(LAT + 2);
    rd(12'h00C);
    rd(12'h004);
    cap_lvl = 1'b0;
    idle(LAT + 2);
    rd(12'h004);
    rd(12'h00C);
    wr(12'h004, 32'h7);
    wr(12'h000, 32'hF);
    cap_lvl = 1'b1;
    idle(LAT + 2);
    cap_lvl = 1'b0;
    idle(LAT + 2);
    rd(12'h004);
    rd(12'h00C);
    rd(12'h004);
    idle(2);
    wr(12'h004, 32'h2);
    idle(2);
    // event lands in the same cycle as a CAPR read, then as a CNTR write
    wr(12'h004, 32'h7);
    cap_lvl = 1'b1;
    idle(LAT);
    rd(12'h00C);
    rd(12'h004);
    cap_lvl = 1'b0;
    idle(LAT);
    wr(12'h008, 32'd5000);
    rd(12'h00C);
    rd(12'h004);
    // short and long pulses: the filter build rejects the first
    wr(12'h004, 32'h7);
    wr(12'h000, 32'h3);
    idle(LAT + 4);
    cap_lvl = 1'b1;
    idle(3);
    cap_lvl = 1'b0;
    idle(LAT + 4);
    rd(12'h004);
    rd(12'h00C);
    wr(12'h004, 32'h7);
    cap_lvl = 1'b1;
    idle(5);
    cap_lvl = 1'b0;
    idle(LAT + 4);
    rd(12'h004);
    rd(12'h00C);
    wr(12'h000, 32'hF);
    cap_lvl = 1'b1;
    idle(3);
    do_reset();
    for (int i = 0; i < 4; i++) rd(addrs[i]);
    idle(LAT + 2);
    rd(12'h004);
    wr(12'h000, 32'hF);
    for (int i = 0; i < 800; i++) begin
      if (run == 0) begin
        cap_lvl = !cap_lvl;
        run = $urandom_range(1, 8);
      end
      run--;
      case ($urandom_range(0, 9))
        4, 5: rd(addrs[$urandom_range(0, 5)]);
        6: wr(12'h004, 32'($urandom_range(0, 7)));
        7: begin
          v = 32'($urandom_range(0, 15));
          v[0] = v[0] | ($urandom_range(0, 3) != 0);
          v[4] = ($urandom_range(0, 7) == 0);
          wr(12'h000, v);
        end
        8: wr(12'h008, $urandom_range(0, 1) != 0 ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
        9: wr(addrs[$urandom_range(3, 5)], $urandom);
        default: idle(1);
      endcase
    end
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
